exe_stage: RTL and testbench
============================

# exe_stage

Execute stage of the 5-stage ARM pipeline and the consumer of the ID/EX pipeline register outputs. It generates the second ALU operand (immediate rotate, register shift, or memory offset) and runs the ALU. It owns the NZCV status register, resolves branch targets back to IF, and captures results into the EX/MEM pipeline register. Memory-stall freeze holds all state.

## Interface
- No parameters; data width fixed at 32.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, synchronous, active-high.
- `freeze` in 1: memory stall. Holds the EX/MEM register and the status register.
- `WB_EN_in`, `MEM_R_EN_in`, `MEM_W_EN_in`, `B_in`, `S_in` in 1 each: control bits from the ID/EX register.
- `EXE_CMD` in 4: ALU command.
- `PC_in` in 32: PC+4 of the instruction.
- `Val_Rn`, `Val_Rm` in 32 each: operand values.
- `imm` in 1: immediate operand flag.
- `Shift_operand` in 12: shifter field.
- `Signed_imm_24` in 24: branch offset.
- `Dest_in` in 4: destination register.
- `SR_in` in 4: NZCV snapshot captured with the instruction; C feeds ADC/SBC.
- `branch_taken` out 1: combinational, equals `B_in`.
- `branch_address` out 32: combinational, `PC_in + (sext(Signed_imm_24) << 2)`.
- `SR_out` out 4: status register {N,Z,C,V}, sent to ID.
- `WB_EN`, `MEM_R_EN`, `MEM_W_EN` out 1 each: registered EX/MEM controls.
- `ALU_result` out 32: registered.
- `ST_val` out 32: registered `Val_Rm`, the store data.
- `Dest` out 4: registered.

## Operation
- Val2 selection:
  - If `MEM_R_EN_in|MEM_W_EN_in`: `{20'b0, Shift_operand}`.
  - Else if `imm`: `{24'b0, Shift_operand[7:0]}` rotated right by `2*Shift_operand[11:8]`.
  - Else: `Val_Rm` shifted by `Shift_operand[11:7]`, type `[6:5]`: 00 LSL, 01 LSR, 10 ASR, 11 ROR. A shift amount of 0 passes `Val_Rm` unchanged.
- ALU, with operands Rn and Val2:
  - 0001 MOV: Val2.
  - 1001 MVN: ~Val2.
  - 0010 ADD: Rn+Val2. Also used by LDR/STR.
  - 0011 ADC: Rn+Val2+C.
  - 0100 SUB/CMP: Rn−Val2.
  - 0101 SBC: Rn−Val2−!C.
  - 0110 AND/TST.
  - 0111 ORR.
  - 1000 EOR.
  - Other codes: result 0, flags unchanged.
- Flags:
  - N = result[31]; Z = (result==0).
  - Add ops: C = bit 32 of the 33-bit sum; V = signed overflow.
  - Sub ops: C = NOT borrow; V = signed overflow.
  - Logic/move ops: C and V are taken from `SR_in`.
- Status register: loads the ALU flags on the clock edge when `S_in && !freeze`.
- EX/MEM register: loads all registered outputs on each edge when `!freeze`. The controls pass through unchanged; a flushed (all-zero) ID/EX entry therefore propagates as a bubble.

## Timing
- `rst`: at the next rising edge, all registered outputs and `SR_out` become 0. `rst` overrides `freeze`.
- Latency: one cycle from ID/EX outputs to EX/MEM outputs.
- `SR_out` reflects an S-instruction one cycle after it is in EXE. A dependent ADC in the immediately following cycle reads C via `SR_in`, which was captured in ID; forwarding of flags is out of scope.
- `branch_taken`/`branch_address`: same-cycle combinational. IF/ID flush is the hazard unit's job.
- `freeze` high: all registers hold and the combinational outputs still track the inputs. An S-instruction under freeze updates SR only on the first unfrozen edge.
- Simultaneous `S_in` and `B_in`: SR is updated and the branch is also taken.
- Reset mid-stream: in-flight EX/MEM content is discarded and no write-back enable survives.

## Structure
- Shared package `arm_defs`:
  - EXE_CMD encodings: `EXE_MOV`, `EXE_MVN`, `EXE_ADD`, `EXE_ADC`, `EXE_SUB`, `EXE_SBC`, `EXE_AND`, `EXE_ORR`, `EXE_EOR`.
  - Shift types `SH_LSL`, `SH_LSR`, `SH_ASR`, `SH_ROR`.
  - NZCV bit indices.
- Sub-module `val2_generator` (combinational): inputs `Val_Rm`, `Shift_operand`, `imm`, mem flag; output Val2.
- ALU, status register and EX/MEM register live in `exe_stage` itself.

## Test plan
- Immediate rotate: `imm=1`, `Shift_operand=12'h4FF`, MOV → next cycle `ALU_result=32'hFF000000`.
- ADDS overflow: Rn=32'h7FFFFFFF, Rm=1, LSL #0, `S_in=1` → `ALU_result=32'h80000000`, `SR_out=4'b1001` one cycle later.
- SUBS equal: Rn=5, Val2=5 → `SR_out=4'b0110` (Z=1, C=1); ADC with `SR_in` C=1 and operands 1+1 → 3.
- ASR shift: Rm=32'h80000000, `Shift_operand[11:5]={5'd4,2'b10}`, MOV → `32'hF8000000`.
- Branch: `PC_in=32'h100`, `Signed_imm_24=24'hFFFFFE`, `B_in=1` → `branch_taken=1`, `branch_address=32'hF8`, same cycle.
- Freeze/reset: hold `freeze` for 3 cycles with changing inputs → outputs frozen and SR frozen. Assert `rst` while frozen → all outputs 0 at the next edge.

Source files
------------

// File: rtl/arm_defs.sv
// Shared ARM pipeline definitions: ALU command encodings, shift types and
// NZCV bit positions used across the pipeline stages.
package arm_defs;

  typedef enum logic [3:0] {
    EXE_MOV = 4'b0001,
    EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011,
    EXE_SUB = 4'b0100,
    EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110,
    EXE_ORR = 4'b0111,
    EXE_EOR = 4'b1000,
    EXE_MVN = 4'b1001
  } exe_cmd_t;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Rotate right; doubling the word keeps an amount of 0 well defined.
  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

endpackage

// File: rtl/val2_generator.sv
// Second ALU operand: memory offset, rotated 8-bit immediate, or shifted Rm.
module val2_generator
  import arm_defs::*;
(
  input  logic [31:0] Val_Rm,
  input  logic [11:0] Shift_operand,
  input  logic        imm,
  input  logic        mem_en,
  output logic [31:0] val2
);

  logic [4:0] shamt;
  logic [4:0] imm_rot;

  assign shamt   = Shift_operand[11:7];
  assign imm_rot = {Shift_operand[11:8], 1'b0};

  always_comb begin
    val2 = Val_Rm;
    if (mem_en) begin
      val2 = {20'b0, Shift_operand};
    end else if (imm) begin
      val2 = ror32({24'b0, Shift_operand[7:0]}, imm_rot);
    end else begin
      case (shift_t'(Shift_operand[6:5]))
        SH_LSL:  val2 = Val_Rm << shamt;
        SH_LSR:  val2 = Val_Rm >> shamt;
        SH_ASR:  val2 = $signed(Val_Rm) >>> shamt;
        SH_ROR:  val2 = ror32(Val_Rm, shamt);
        default: val2 = Val_Rm;
      endcase
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand-2 generation, ALU, NZCV status register, branch
// target resolution and the EX/MEM pipeline register.
module exe_stage
  import arm_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        WB_EN_in,
  input  logic        MEM_R_EN_in,
  input  logic        MEM_W_EN_in,
  input  logic        B_in,
  input  logic        S_in,
  input  logic [3:0]  EXE_CMD,
  input  logic [31:0] PC_in,
  input  logic [31:0] Val_Rn,
  input  logic [31:0] Val_Rm,
  input  logic        imm,
  input  logic [11:0] Shift_operand,
  input  logic [23:0] Signed_imm_24,
  input  logic [3:0]  Dest_in,
  input  logic [3:0]  SR_in,
  output logic        branch_taken,
  output logic [31:0] branch_address,
  output logic [3:0]  SR_out,
  output logic        WB_EN,
  output logic        MEM_R_EN,
  output logic        MEM_W_EN,
  output logic [31:0] ALU_result,
  output logic [31:0] ST_val,
  output logic [3:0]  Dest
);

  logic [31:0] val2;
  logic [31:0] op_b;
  logic        carry_in;
  logic [32:0] sum;
  logic [31:0] alu_res;
  logic [3:0]  alu_flags;

  logic [3:0]  sr_reg;
  logic        wb_en_reg, mem_r_en_reg, mem_w_en_reg;
  logic [31:0] alu_result_reg, st_val_reg;
  logic [3:0]  dest_reg;

  val2_generator u_val2 (
    .Val_Rm        (Val_Rm),
    .Shift_operand (Shift_operand),
    .imm           (imm),
    .mem_en        (MEM_R_EN_in | MEM_W_EN_in),
    .val2          (val2)
  );

  assign branch_taken   = B_in;
  assign branch_address = PC_in + {{6{Signed_imm_24[23]}}, Signed_imm_24, 2'b00};

  // Subtraction is done as Rn + ~Val2 + cin so carry-out is directly NOT borrow.
  always_comb begin
    op_b     = val2;
    carry_in = 1'b0;
    case (EXE_CMD)
      EXE_ADC: carry_in = SR_in[FLAG_C];
      EXE_SUB: begin op_b = ~val2; carry_in = 1'b1; end
      EXE_SBC: begin op_b = ~val2; carry_in = SR_in[FLAG_C]; end
      default: ;
    endcase
    sum = {1'b0, Val_Rn} + {1'b0, op_b} + {32'b0, carry_in};
  end

  always_comb begin
    alu_res   = 32'b0;
    alu_flags = SR_in;
    case (EXE_CMD)
      EXE_MOV: alu_res = val2;
      EXE_MVN: alu_res = ~val2;
      EXE_AND: alu_res = Val_Rn & val2;
      EXE_ORR: alu_res = Val_Rn | val2;
      EXE_EOR: alu_res = Val_Rn ^ val2;
      EXE_ADD, EXE_ADC, EXE_SUB, EXE_SBC: begin
        alu_res           = sum[31:0];
        alu_flags[FLAG_C] = sum[32];
        alu_flags[FLAG_V] = (Val_Rn[31] == op_b[31]) && (sum[31] != Val_Rn[31]);
      end
      default: ;
    endcase
    alu_flags[FLAG_N] = alu_res[31];
    alu_flags[FLAG_Z] = (alu_res == 32'b0);
    // Undefined commands leave the status register as it is.
    case (EXE_CMD)
      EXE_MOV, EXE_MVN, EXE_ADD, EXE_ADC, EXE_SUB,
      EXE_SBC, EXE_AND, EXE_ORR, EXE_EOR: ;
      default: alu_flags = sr_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_reg <= 4'b0;
    end else if (S_in && !freeze) begin
      sr_reg <= alu_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_reg      <= 1'b0;
      mem_r_en_reg   <= 1'b0;
      mem_w_en_reg   <= 1'b0;
      alu_result_reg <= 32'b0;
      st_val_reg     <= 32'b0;
      dest_reg       <= 4'b0;
    end else if (!freeze) begin
      wb_en_reg      <= WB_EN_in;
      mem_r_en_reg   <= MEM_R_EN_in;
      mem_w_en_reg   <= MEM_W_EN_in;
      alu_result_reg <= alu_res;
      st_val_reg     <= Val_Rm;
      dest_reg       <= Dest_in;
    end
  end

  assign SR_out     = sr_reg;
  assign WB_EN      = wb_en_reg;
  assign MEM_R_EN   = mem_r_en_reg;
  assign MEM_W_EN   = mem_w_en_reg;
  assign ALU_result = alu_result_reg;
  assign ST_val     = st_val_reg;
  assign Dest       = dest_reg;

endmodule

// File: tb/tb_exe_stage.sv
// Directed-vector bench for exe_stage with hand-computed expected values.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst, freeze;
  logic        WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in;
  logic [3:0]  EXE_CMD;
  logic [31:0] PC_in, Val_Rn, Val_Rm;
  logic        imm;
  logic [11:0] Shift_operand;
  logic [23:0] Signed_imm_24;
  logic [3:0]  Dest_in, SR_in;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic [3:0]  SR_out;
  logic        WB_EN, MEM_R_EN, MEM_W_EN;
  logic [31:0] ALU_result, ST_val;
  logic [3:0]  Dest;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  exe_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .WB_EN_in(WB_EN_in), .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
    .B_in(B_in), .S_in(S_in), .EXE_CMD(EXE_CMD), .PC_in(PC_in),
    .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .imm(imm), .Shift_operand(Shift_operand),
    .Signed_imm_24(Signed_imm_24), .Dest_in(Dest_in), .SR_in(SR_in),
    .branch_taken(branch_taken), .branch_address(branch_address), .SR_out(SR_out),
    .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .ALU_result(ALU_result), .ST_val(ST_val), .Dest(Dest)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic clear_inputs();
    WB_EN_in = 0; MEM_R_EN_in = 0; MEM_W_EN_in = 0; B_in = 0; S_in = 0;
    EXE_CMD = 4'b0; PC_in = 32'b0; Val_Rn = 32'b0; Val_Rm = 32'b0; imm = 0;
    Shift_operand = 12'b0; Signed_imm_24 = 24'b0; Dest_in = 4'b0; SR_in = 4'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    rst = 1; freeze = 0;
    WB_EN_in = 1; Val_Rm = 32'h1234; EXE_CMD = 4'b0001; Dest_in = 4'd9;
    step();
    check("rst_alu", ALU_result, 32'h0);
    check("rst_wb", {31'b0, WB_EN}, 32'h0);
    check("rst_sr", {28'b0, SR_out}, 32'h0);
    check("rst_dest", {28'b0, Dest}, 32'h0);
    check("rst_st", ST_val, 32'h0);
    rst = 0;

    // MOV #0xFF ror 8
    clear_inputs(); EXE_CMD = 4'b0001; imm = 1; Shift_operand = 12'h4FF;
    WB_EN_in = 1; Dest_in = 4'd3;
    step();
    check("mov_imm", ALU_result, 32'hFF000000);
    check("mov_dest", {28'b0, Dest}, 32'd3);
    check("mov_wb", {31'b0, WB_EN}, 32'd1);
    check("mov_sr_kept", {28'b0, SR_out}, 32'h0);

    // ADDS overflow
    clear_inputs(); EXE_CMD = 4'b0010; Val_Rn = 32'h7FFFFFFF; Val_Rm = 32'd1; S_in = 1;
    step();
    check("adds_res", ALU_result, 32'h80000000);
    check("adds_sr", {28'b0, SR_out}, 32'b1001);

    // SUBS equal
    clear_inputs(); EXE_CMD = 4'b0100; Val_Rn = 32'd5; Val_Rm = 32'd5; S_in = 1;
    step();
    check("subs_res", ALU_result, 32'h0);
    check("subs_sr", {28'b0, SR_out}, 32'b0110);

    // ADC with C=1, no S
    clear_inputs(); EXE_CMD = 4'b0011; Val_Rn = 32'd1; Val_Rm = 32'd1; SR_in = 4'b0010;
    step();
    check("adc_res", ALU_result, 32'd3);
    check("adc_sr_kept", {28'b0, SR_out}, 32'b0110);

    // SBC with C=0: 5-3-1
    clear_inputs(); EXE_CMD = 4'b0101; Val_Rn = 32'd5; Val_Rm = 32'd3;
    step();
    check("sbc_res", ALU_result, 32'd1);

    // Undefined command with S set: result 0, SR untouched
    clear_inputs(); EXE_CMD = 4'b0000; Val_Rn = 32'd7; Val_Rm = 32'd9; S_in = 1;
    step();
    check("undef_res", ALU_result, 32'h0);
    check("undef_sr", {28'b0, SR_out}, 32'b0110);

    // Shifter: ASR #4, LSR #4, ROR #1
    clear_inputs(); EXE_CMD = 4'b0001; Val_Rm = 32'h80000000; Shift_operand = 12'h240;
    step();
    check("asr4", ALU_result, 32'hF8000000);
    clear_inputs(); EXE_CMD = 4'b0001; Val_Rm = 32'h000000F0; Shift_operand = 12'h220;
    step();
    check("lsr4", ALU_result, 32'h0000000F);
    clear_inputs(); EXE_CMD = 4'b0001; Val_Rm = 32'h00000001; Shift_operand = 12'h0E0;
    step();
    check("ror1", ALU_result, 32'h80000000);

    // Logic ops: AND, ORR, EOR, MVN
    clear_inputs(); EXE_CMD = 4'b0110; Val_Rn = 32'hFF00FF00; Val_Rm = 32'h0FF00FF0;
    step();
    check("and", ALU_result, 32'h0F000F00);
    EXE_CMD = 4'b0111;
    step();
    check("orr", ALU_result, 32'hFFF0FFF0);
    EXE_CMD = 4'b1000;
    step();
    check("eor", ALU_result, 32'hF0F0F0F0);
    EXE_CMD = 4'b1001;
    step();
    check("mvn", ALU_result, 32'hF00FF00F);

    // Branch, combinational same cycle
    clear_inputs(); PC_in = 32'h100; Signed_imm_24 = 24'hFFFFFE; B_in = 1;
    #1;
    check("br_taken", {31'b0, branch_taken}, 32'd1);
    check("br_addr", branch_address, 32'h000000F8);

    // STR: offset from Shift_operand even with imm set
    clear_inputs(); EXE_CMD = 4'b0010; MEM_W_EN_in = 1; imm = 1;
    Val_Rn = 32'h1000; Val_Rm = 32'hDEADBEEF; Shift_operand = 12'hFFF;
    step();
    check("str_addr", ALU_result, 32'h00001FFF);
    check("str_val", ST_val, 32'hDEADBEEF);
    check("str_wen", {31'b0, MEM_W_EN}, 32'd1);

    // Freeze for 3 cycles with an ADDS and changing inputs
    clear_inputs(); freeze = 1; EXE_CMD = 4'b0010; S_in = 1;
    Val_Rn = 32'h7FFFFFFF; Val_Rm = 32'd1; WB_EN_in = 1;
    for (int i = 0; i < 3; i++) begin
      Dest_in = 4'(i + 5);
      PC_in = 32'h200 + 32'(i * 16);
      step();
      check("frz_alu", ALU_result, 32'h00001FFF);
      check("frz_sr", {28'b0, SR_out}, 32'b0110);
      check("frz_wen", {31'b0, MEM_W_EN}, 32'd1);
      check("frz_br", branch_address, 32'h200 + 32'(i * 16));
    end
    freeze = 0;
    step();
    check("unfrz_alu", ALU_result, 32'h80000000);
    check("unfrz_sr", {28'b0, SR_out}, 32'b1001);
    check("unfrz_dest", {28'b0, Dest}, 32'd7);

    // Reset while frozen clears everything
    freeze = 1; rst = 1;
    step();
    check("rstfrz_alu", ALU_result, 32'h0);
    check("rstfrz_sr", {28'b0, SR_out}, 32'h0);
    check("rstfrz_wb", {31'b0, WB_EN}, 32'h0);
    check("rstfrz_dest", {28'b0, Dest}, 32'h0);
    rst = 0; freeze = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
